// File: rtl/uart_sched_pkg.sv
// Shared constants for the round-robin UART transmit scheduler.
package uart_sched_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_ISSUE   = 2'd1;
  localparam state_t ST_WAIT_HI = 2'd2;
  localparam state_t ST_WAIT_LO = 2'd3;

  // Index width for a count of n items, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or after ptr_i.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 2,
  localparam int unsigned IW = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IW-1:0]    gnt_idx_o,
  output logic             any_o
);

  logic [IW-1:0] cand;

  // Scan requesters from ptr_i with wrap-around and take the first one asserted.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = IW'((32'(ptr_i) + k) % N_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Shares one byte-wide UART transmitter among N_REQ word producers, serving
// them round-robin and serialising each BYTES-byte word through the
// uart_tx_en / uart_tx_busy handshake.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = 2,
  parameter int unsigned BYTES     = 32,
  parameter int unsigned MSB_FIRST = 1,
  localparam int unsigned IW = idx_w(N_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*BYTES*BYTE_W-1:0] req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          uart_tx_en,
  output logic [BYTE_W-1:0]             uart_tx_data,
  input  logic                          uart_tx_busy,
  output logic                          sched_active,
  output logic [IW-1:0]                 grant_id,
  output logic                          done
);

  localparam int unsigned WORD_W = BYTES * BYTE_W;
  localparam int unsigned CW     = idx_w(BYTES);

  state_t              state_q,    state_d;
  logic [IW-1:0]       rr_ptr_q,   rr_ptr_d;
  logic [CW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   shreg_q,    shreg_d;
  logic [IW-1:0]       grant_q,    grant_d;
  logic                done_q,     done_d;

  logic [N_REQ-1:0]    arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;
  logic [WORD_W-1:0]   word_sel;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req_i     (req_valid),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx),
    .any_o     (arb_any)
  );

  // Mux the granted requester's word out of the flat data bus.
  always_comb begin
    word_sel = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (arb_gnt[i]) word_sel = req_data[i*WORD_W +: WORD_W];
    end
  end

  // Next-state logic: accept in IDLE, strobe once per byte, wait for busy to cycle.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    grant_d    = grant_q;
    done_d     = 1'b0;
    req_ready  = '0;
    uart_tx_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          req_ready  = arb_gnt;
          shreg_d    = word_sel;
          grant_d    = arb_idx;
          byte_cnt_d = '0;
          if (32'(arb_idx) == N_REQ - 1) rr_ptr_d = '0;
          else                           rr_ptr_d = arb_idx + 1'b1;
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Holding here while busy keeps a transmitter left running across a reset intact.
        if (!uart_tx_busy) begin
          uart_tx_en = 1'b1;
          state_d    = ST_WAIT_HI;
        end
      end
      ST_WAIT_HI: begin
        if (uart_tx_busy) state_d = ST_WAIT_LO;
      end
      ST_WAIT_LO: begin
        if (!uart_tx_busy) begin
          if (32'(byte_cnt_q) == BYTES - 1) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            shreg_d    = (MSB_FIRST != 0) ? (shreg_q << BYTE_W) : (shreg_q >> BYTE_W);
            state_d    = ST_ISSUE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      grant_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
    end
  end

  assign uart_tx_data = (MSB_FIRST != 0) ? shreg_q[WORD_W-1 -: BYTE_W] : shreg_q[BYTE_W-1:0];
  assign sched_active = (state_q != ST_IDLE);
  assign grant_id     = grant_q;
  assign done         = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Self-checking bench for uart_tx_sched: a bench transmitter model, a
// round-robin reference and a byte scoreboard per DUT instance.
module tb_uart_tx_sched;

  localparam int unsigned NA = 2, BA = 4, WA = BA * 8;
  localparam int unsigned NB = 3, BB = 4, WB = BB * 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- DUT A: N_REQ=2, BYTES=4, MSB first ----------------
  logic [NA-1:0]    a_valid = '0;
  logic [NA*WA-1:0] a_data  = '0;
  logic [NA-1:0]    a_ready;
  logic             a_en, a_active, a_done;
  logic [7:0]       a_txd;
  logic [0:0]       a_gid;
  logic             a_busy = 1'b0;

  uart_tx_sched #(.N_REQ(NA), .BYTES(BA), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .reset(rst), .req_valid(a_valid), .req_data(a_data), .req_ready(a_ready),
    .uart_tx_en(a_en), .uart_tx_data(a_txd), .uart_tx_busy(a_busy),
    .sched_active(a_active), .grant_id(a_gid), .done(a_done));

  // Bench transmitter A: busy rises the cycle after en and stays high a_hold cycles.
  int unsigned a_hold = 5, a_cnt = 0;
  always @(posedge clk) begin
    if (a_en) begin
      a_busy <= 1'b1;
      a_cnt  <= a_hold;
    end else if (a_cnt != 0) begin
      a_cnt <= a_cnt - 1;
      if (a_cnt == 1) a_busy <= 1'b0;
    end
  end

  // Reference model and scoreboard A.
  logic [7:0]  a_q[$];
  int unsigned a_gq[$];
  int unsigned acc_cyc[$], done_cyc[$], gid_log[$];
  int unsigned acc_cnt[NA];
  int unsigned m_ptr = 0, m_bytes = 0, last_hi = 0;
  bit          m_busy = 0, gap_chk = 0, a_prev_busy = 0;

  always @(negedge clk) begin
    if (rst) begin
      a_q.delete(); a_gq.delete();
      m_ptr = 0; m_busy = 0; m_bytes = 0; gap_chk = 0;
    end else begin
      if (a_busy && !a_prev_busy && gap_chk) begin
        check_val("byte_gap", cyc - last_hi, 3);
        gap_chk = 0;
      end
      if (a_done) begin
        check_val("done_lat", cyc - (last_hi + 1), 1);
        check_val("done_bytes", m_bytes, BA);
        if (a_gq.size() == 0) check_val("done_unexpected", 1, 0);
        else                  check_val("done_gid", a_gid, a_gq.pop_front());
        gid_log.push_back(a_gid);
        done_cyc.push_back(cyc);
        m_busy = 0; m_bytes = 0;
      end
      if (a_en) begin
        check_val("en_while_busy", a_busy, 0);
        if (a_q.size() == 0) check_val("en_unexpected", 1, 0);
        else                 check_val("tx_byte", a_txd, a_q.pop_front());
        gap_chk = (m_bytes != 0);
        m_bytes++;
      end
      if (!m_busy && a_valid != 0) begin
        int unsigned pred;
        logic [WA-1:0] w;
        pred = 0;
        for (int k = NA - 1; k >= 0; k--)
          if (a_valid[(m_ptr + k) % NA]) pred = (m_ptr + k) % NA;
        check_val("ready_grant", a_ready, 64'(1) << pred);
        w = a_data[pred*WA +: WA];
        for (int b = 0; b < BA; b++) a_q.push_back(w[WA-1-8*b -: 8]);
        a_gq.push_back(pred);
        acc_cyc.push_back(cyc);
        acc_cnt[pred]++;
        m_ptr = (pred + 1) % NA;
        m_busy = 1;
      end else if (a_ready != 0) begin
        check_val("ready_spurious", a_ready, 0);
      end
    end
    if (a_busy) last_hi = cyc;
    a_prev_busy = a_busy;
  end

  // ---------------- DUT B: N_REQ=3, BYTES=4, LSB first ----------------
  logic [NB-1:0]    b_valid = '0;
  logic [NB*WB-1:0] b_data  = '0;
  logic [NB-1:0]    b_ready;
  logic             b_en, b_active, b_done;
  logic [7:0]       b_txd;
  logic [1:0]       b_gid;
  logic             b_busy = 1'b0;
  int unsigned      b_cnt = 0;

  uart_tx_sched #(.N_REQ(NB), .BYTES(BB), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .reset(rst), .req_valid(b_valid), .req_data(b_data), .req_ready(b_ready),
    .uart_tx_en(b_en), .uart_tx_data(b_txd), .uart_tx_busy(b_busy),
    .sched_active(b_active), .grant_id(b_gid), .done(b_done));

  // Bench transmitter B with a fixed 3-cycle busy.
  always @(posedge clk) begin
    if (b_en) begin
      b_busy <= 1'b1;
      b_cnt  <= 3;
    end else if (b_cnt != 0) begin
      b_cnt <= b_cnt - 1;
      if (b_cnt == 1) b_busy <= 1'b0;
    end
  end

  logic [7:0]  b_q[$];
  int unsigned b_gq[$];
  int unsigned b_ptr = 0, b_words = 0;
  bit          b_mbusy = 0;

  always @(negedge clk) begin
    if (rst) begin
      b_q.delete(); b_gq.delete(); b_ptr = 0; b_mbusy = 0;
    end else begin
      if (b_done) begin
        if (b_gq.size() == 0) check_val("b_done_unexpected", 1, 0);
        else                  check_val("b_done_gid", b_gid, b_gq.pop_front());
        b_mbusy = 0;
        b_words++;
      end
      if (b_en) begin
        check_val("b_en_while_busy", b_busy, 0);
        if (b_q.size() == 0) check_val("b_en_unexpected", 1, 0);
        else                 check_val("b_tx_byte", b_txd, b_q.pop_front());
      end
      if (!b_mbusy && b_valid != 0) begin
        int unsigned pred;
        logic [WB-1:0] w;
        pred = 0;
        for (int k = NB - 1; k >= 0; k--)
          if (b_valid[(b_ptr + k) % NB]) pred = (b_ptr + k) % NB;
        check_val("b_ready_grant", b_ready, 64'(1) << pred);
        w = b_data[pred*WB +: WB];
        for (int b = 0; b < BB; b++) b_q.push_back(w[8*b +: 8]);
        b_gq.push_back(pred);
        b_ptr = (pred + 1) % NB;
        b_mbusy = 1;
      end else if (b_ready != 0) begin
        check_val("b_ready_spurious", b_ready, 0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_reset_a(input string pfx);
    check_val({pfx, "_ready"},  a_ready,  0);
    check_val({pfx, "_en"},     a_en,     0);
    check_val({pfx, "_txdata"}, a_txd,    0);
    check_val({pfx, "_active"}, a_active, 0);
    check_val({pfx, "_gid"},    a_gid,    0);
    check_val({pfx, "_done"},   a_done,   0);
  endtask

  // Offer one word on requester r, drop valid after accept and scramble its data.
  task automatic a_send(input int unsigned r, input logic [31:0] w, input int unsigned budget);
    int unsigned t;
    bit got;
    t = 0; got = 0;
    @(posedge clk); #1;
    a_data[r*WA +: WA] = w;
    a_valid[r] = 1'b1;
    while (!got && t < budget) begin
      @(negedge clk);
      if (a_ready[r]) got = 1;
      t++;
    end
    if (!got) check_val("accept_timeout", 0, 1);
    @(posedge clk); #1;
    a_valid[r] = 1'b0;
    a_data[r*WA +: WA] = $urandom;
  endtask

  task automatic wait_words(input int unsigned target, input int unsigned budget);
    int unsigned t;
    t = 0;
    while (done_cyc.size() < target && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (done_cyc.size() < target) check_val("done_timeout", done_cyc.size(), target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, t, a0, a1;
    logic [NA-1:0] rdy;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_reset_a("rst");
    check_val("b_rst_ready", b_ready, 0);
    check_val("b_rst_en", b_en, 0);
    rst = 1'b0;

    // Single word on requester 0.
    base = done_cyc.size();
    a0 = acc_cnt[0];
    a_send(0, 32'hA1B2C3D4, 50);
    wait_words(base + 1, 200);
    check_val("single_accepts", acc_cnt[0] - a0, 1);
    check_val("single_gid", a_gid, 0);

    // Contention from reset: requester 0 first, requester 1 taken on the done cycle.
    @(posedge clk); #1;
    rst = 1'b1;
    a_data  = {32'h55667788, 32'h11223344};
    a_valid = 2'b11;
    @(posedge clk); #1;
    rst = 1'b0;
    base = done_cyc.size();
    t = 0;
    while (a_valid != 0 && t < 300) begin
      @(negedge clk);
      t++;
      rdy = a_ready & a_valid;
      if (rdy != 0) begin
        @(posedge clk); #1;
        a_valid = a_valid & ~rdy;
      end
    end
    wait_words(base + 2, 300);
    if (done_cyc.size() >= base + 2 && acc_cyc.size() >= 2)
      check_val("contend_accept_on_done", acc_cyc[acc_cyc.size()-1], done_cyc[base]);

    // Round-robin with both requesters held valid for four words.
    base = done_cyc.size();
    a0 = acc_cnt[0]; a1 = acc_cnt[1];
    begin
      int unsigned acc_base;
      acc_base = acc_cyc.size();
      a_valid = 2'b11;
      t = 0;
      while (acc_cyc.size() < acc_base + 4 && t < 600) begin
        @(negedge clk);
        t++;
        rdy = a_ready & a_valid;
        if (rdy != 0) begin
          @(posedge clk); #1;
          for (int r = 0; r < NA; r++) if (rdy[r]) a_data[r*WA +: WA] = $urandom;
          if (acc_cyc.size() >= acc_base + 4) a_valid = '0;
        end
      end
      a_valid = '0;
    end
    wait_words(base + 4, 600);
    for (int i = 0; i < 4; i++)
      if (gid_log.size() > base + i) check_val("rr_gid_seq", gid_log[base+i], i % 2);
    check_val("rr_accepts0", acc_cnt[0] - a0, 2);
    check_val("rr_accepts1", acc_cnt[1] - a1, 2);

    // Long busy (1000 cycles per byte); requester 0 glitches valid while a word is in flight.
    a_hold = 1000;
    base = done_cyc.size();
    a_send(1, 32'hDEADBEEF, 50);
    repeat (20) @(posedge clk);
    #1 a_valid[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1 a_valid[0] = 1'b0;
    wait_words(base + 1, 5000);
    a_hold = 5;

    // Reset during byte 2 of 4 while the transmitter is busy.
    a_hold = 40;
    a_send(0, 32'hCAFEF00D, 50);
    t = 0;
    while (m_bytes < 2 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (m_bytes < 2) check_val("midword_timeout", m_bytes, 2);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1 check_reset_a("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    base = done_cyc.size();
    a_send(1, 32'h01020304, 50);
    wait_words(base + 1, 1000);
    a_hold = 5;

    // LSB-first instance, only requester 2 active (others skipped immediately).
    @(posedge clk); #1;
    b_data[2*WB +: WB] = 32'h0A0B0C0D;
    b_valid = 3'b100;
    @(negedge clk);
    check_val("b_ready_first_cycle", b_ready, 3'b100);
    @(posedge clk); #1;
    b_valid = '0;
    b_data[2*WB +: WB] = 32'hFFFFFFFF;
    t = 0;
    while (b_words < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (b_words < 1) check_val("b_done_timeout", b_words, 1);

    repeat (5) @(posedge clk);
    #1;
    check_val("a_queue_drained", a_q.size(), 0);
    check_val("b_queue_drained", b_q.size(), 0);
    check_val("a_idle_at_end", a_active, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one uart_tx byte transmitter between N_REQ requesters. Each requester is a hash/signature engine.
- Each requester hands over a fixed-length BYTES-byte word. The block latches it, serialises it byte by byte through the uart_tx_en / uart_tx_busy handshake, and pulses done at the end.
- Sits between the XMSS datapath result registers and the UART transmitter.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- BYTES, 32, bytes per word (XMSS n); must be at least 1.
- MSB_FIRST, 1, 1 = send byte [BYTES*8-1 -: 8] first; 0 = send byte [7:0] first.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  N_REQ  requester i has a word ready.
- req_data  in  N_REQ*BYTES*8  word of requester i at [i*BYTES*8 +: BYTES*8].
- req_ready  out  N_REQ  one-hot accept strobe; the word transfers when valid and ready are both high.
- uart_tx_en  out  1  one-cycle send strobe to the transmitter.
- uart_tx_data  out  8  byte to send; valid while uart_tx_en is high.
- uart_tx_busy  in  1  transmitter busy. It rises the cycle after uart_tx_en and falls after the stop bit.
- sched_active  out  1  a word is in flight.
- grant_id  out  $clog2(N_REQ) (min 1)  index of the current or last granted requester.
- done  out  1  one-cycle pulse after the last byte of a word has fully left the transmitter.

Behaviour:
- Reset (async, any state): FSM to IDLE; rr_ptr = 0, byte_cnt = 0, shift register = 0.
  - Outputs: req_ready = 0, uart_tx_en = 0, uart_tx_data = 0, sched_active = 0, grant_id = 0, done = 0.
- FSM states: IDLE, ISSUE, WAIT_HI, WAIT_LO.
- IDLE:
  - Grant g = first requester with req_valid high, searching rr_ptr, rr_ptr+1, ... with modulo-N_REQ wrap.
  - req_ready[g] = 1 combinationally in this cycle only; all other req_ready bits are 0. No request means req_ready = 0.
  - On the accept edge: shift register <= req_data slice g; grant_id <= g; rr_ptr <= (g+1) mod N_REQ; byte_cnt <= 0; go to ISSUE.
- ISSUE:
  - If uart_tx_busy = 0: uart_tx_en = 1 for this cycle, uart_tx_data = current byte, next state WAIT_HI.
  - If uart_tx_busy = 1: hold in ISSUE with uart_tx_en = 0. This covers a transmitter still sending after a controller reset.
- WAIT_HI: stay until uart_tx_busy = 1 (nominally one cycle), then go to WAIT_LO. uart_tx_en = 0 here; no byte is ever strobed twice.
- WAIT_LO: stay while uart_tx_busy = 1. When uart_tx_busy = 0:
  - If byte_cnt = BYTES-1: done = 1 (registered, exactly one cycle), go to IDLE.
  - Otherwise: byte_cnt++, shift the register by 8 bits (direction per MSB_FIRST), go to ISSUE.
- uart_tx_data is driven only from the shift register's head byte. It is stable from ISSUE until the next shift.
- sched_active = 1 in ISSUE, WAIT_HI and WAIT_LO.
- Throughput: consecutive bytes have exactly 3 idle clk cycles of controller overhead after busy falls (WAIT_LO exit, ISSUE, transmitter IDLE→START).
  - The next word may be accepted in the cycle the FSM enters IDLE (the cycle done is high).
- Fairness:
  - With all requesters continuously valid, grants rotate 0,1,…,N_REQ-1,0.
  - A requester that drops valid before accept loses nothing, and rr_ptr is unchanged.
  - req_data is sampled only on the accept edge; later changes do not affect the word in flight.
- byte_cnt width is $clog2(BYTES) (min 1). BYTES = 1 means done follows the first byte.
- Unused requesters (valid never high) are skipped with no idle-slot penalty.

Decomposition:
- Package uart_sched_pkg: FSM state encoding (IDLE=0, ISSUE=1, WAIT_HI=2, WAIT_LO=3) and the byte-width constant 8.
- One sub-module, rr_arbiter: inputs req and ptr; outputs one-hot gnt, gnt index and any. Purely combinational, parameterised by N_REQ.
- FSM, counters and the shift register stay in uart_tx_sched.

Test Plan:
- Single word (N_REQ=2, BYTES=4, MSB_FIRST=1): req_valid = 01, data 0xA1B2C3D4 → req_ready[0] pulses once.
  - uart_tx_en strobes 4 times with bytes A1, B2, C3, D4; a decoded TX line shows the same; one done pulse; grant_id = 0.
- Contention: both valid from reset, data0 = 0x11223344, data1 = 0x55667788 → requester 0 is served first, then requester 1.
  - Data1 is accepted in the cycle done rises; the TX line carries 11 22 33 44 55 66 77 88.
- Round-robin: both valid held high for 4 words → grant_id sequence 0,1,0,1; each req_ready pulses exactly 2 times.
- LSB-first (MSB_FIRST=0): data 0x0A0B0C0D → TX bytes 0D, 0C, 0B, 0A.
- Reset mid-word: assert reset during byte 2 of 4 while the transmitter is busy → outputs reset to 0 asynchronously.
  - After release, a new request is accepted, but uart_tx_en is held until uart_tx_busy falls; no lost or duplicated strobe.
- Back-pressure model: a bench transmitter holds busy for 5 cycles or 1000 cycles per byte → exactly one uart_tx_en per byte.
  - 3-cycle gap between busy fall and the next busy rise; done appears exactly one cycle after the final busy fall.
